// File: rtl/gaussian_pkg.sv
// Shared definitions for the gaussian_blur streaming stage.
// Contents:
//   state_e       - FSM states (PROLOGUE, FILTER, OUTPUT)
//   BINOM_W       - 5-entry binomial weights [1 4 6 4 1]; the kernel is their outer product
//   ROUND_C       - rounding constant added before the final shift
//   SHIFT_C       - normalisation shift (kernel weight sum is 256)
//   tap_weight()  - 2-D kernel weight for tap (dy,dx), indices 0..4
package gaussian_pkg;

  typedef enum logic [1:0] {
    PROLOGUE = 2'd0,
    FILTER   = 2'd1,
    OUTPUT   = 2'd2
  } state_e;

  localparam logic [4:0][7:0] BINOM_W = {8'd1, 8'd4, 8'd6, 8'd4, 8'd1};
  localparam logic [15:0]     ROUND_C = 16'd128;
  localparam int              SHIFT_C = 8;

  // Outer-product weight; the largest value is 36, so 16 bits is ample.
  function automatic logic [15:0] tap_weight(input logic [2:0] dy, input logic [2:0] dx);
    return {8'd0, BINOM_W[dy]} * {8'd0, BINOM_W[dx]};
  endfunction

endpackage

// File: rtl/gaussian_blur_if.sv
// FIFO-side handshake bundle of the gaussian_blur stage.
// Signals:
//   in_rd_en  - pop request to the upstream FIFO
//   in_empty  - upstream FIFO empty
//   in_dout   - upstream FIFO head pixel (show-ahead)
//   out_wr_en - push request to the downstream FIFO
//   out_full  - downstream FIFO full
//   out_din   - blurred pixel pushed downstream
// Modports: master = the blur stage, slave = the FIFO side.
interface gaussian_blur_if;
  logic       in_rd_en;
  logic       in_empty;
  logic [7:0] in_dout;
  logic       out_wr_en;
  logic       out_full;
  logic [7:0] out_din;

  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output out_wr_en,
    input  out_full,
    output out_din
  );

  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  out_wr_en,
    output out_full,
    input  out_din
  );
endinterface

// File: rtl/gaussian_window_sum.sv
// Combinational 5x5 binomial weighted sum with rounding.
// Ports:
//   taps_i   - 25 window bytes, taps_i[(dy+2)*5 + (dx+2)] for dy,dx in -2..2
//   result_o - (sum(w*p) + 128) >> 8
// The accumulator tops out at 65280 + 128 = 65408, so 16 bits never overflow.
module gaussian_window_sum
  import gaussian_pkg::*;
(
  input  logic [24:0][7:0] taps_i,
  output logic [7:0]       result_o
);

  logic [15:0] acc_s;

  // Weighted sum over all 25 taps, seeded with the rounding constant.
  always_comb begin
    acc_s = ROUND_C;
    for (int dy = 0; dy < 5; dy++) begin
      for (int dx = 0; dx < 5; dx++) begin
        acc_s = acc_s + tap_weight(3'(dy), 3'(dx)) * {8'd0, taps_i[5'(dy * 5 + dx)]};
      end
    end
  end

  assign result_o = acc_s[SHIFT_C +: 8];

endmodule

// File: rtl/gaussian_blur.sv
// Streaming 5x5 Gaussian smoothing of 8-bit raster frames.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - FIFO handshake (gaussian_blur_if.master)
// A 4*WIDTH+5 byte shift register holds the window; index 0 is the oldest
// byte and the centre sits at 2*WIDTH+2. Each output pixel takes one FILTER
// cycle (compute + shift) and one OUTPUT cycle (push). Border pixels pass the
// centre byte through. Counters clear at the last pixel so every frame
// realigns to (0,0).
module gaussian_blur
  import gaussian_pkg::*;
#(
  parameter int WIDTH  = 568,
  parameter int HEIGHT = 320
) (
  input  logic            clock,
  input  logic            reset_n,
  gaussian_blur_if.master bus
);

  localparam int SR_LEN   = 4 * WIDTH + 5;
  localparam int CENTRE   = 2 * WIDTH + 2;
  localparam int NPIX     = WIDTH * HEIGHT;
  localparam int CNT_W    = $clog2(NPIX + 1);
  localparam int COL_W    = $clog2(WIDTH);
  localparam int ROW_W    = $clog2(HEIGHT);

  localparam logic [CNT_W-1:0] NPIX_C     = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0] PROLOG_C   = CNT_W'(2 * WIDTH + 3);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LO     = COL_W'(2);
  localparam logic [COL_W-1:0] COL_HI     = COL_W'(WIDTH - 3);
  localparam logic [ROW_W-1:0] ROW_LO     = ROW_W'(2);
  localparam logic [ROW_W-1:0] ROW_HI     = ROW_W'(HEIGHT - 3);

  state_e           state_q;
  logic [CNT_W-1:0] rd_count_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [7:0]       result_q;
  logic             run_q;
  logic [7:0]       sr_q [SR_LEN];

  logic             exhausted_s;
  logic             in_rd_en_s;
  logic             out_wr_en_s;
  logic             shift_en_s;
  logic [7:0]       shift_in_s;
  logic             border_s;
  logic             filter_go_s;
  logic             last_pix_s;
  logic [7:0]       sum_s;
  logic [7:0]       result_d;
  logic [24:0][7:0] taps_s;

  assign exhausted_s = (rd_count_q == NPIX_C);
  assign border_s    = (row_q < ROW_LO) || (row_q > ROW_HI) || (col_q < COL_LO) || (col_q > COL_HI);
  assign last_pix_s  = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign filter_go_s = (state_q == FILTER) && (!bus.in_empty || exhausted_s);

  // Pop decision; run_q keeps the pop low while reset is held and for the
  // first edge after release.
  always_comb begin
    in_rd_en_s = 1'b0;
    if (run_q) begin
      case (state_q)
        PROLOGUE: in_rd_en_s = !bus.in_empty && (rd_count_q < PROLOG_C);
        FILTER:   in_rd_en_s = !bus.in_empty && !exhausted_s;
        default:  in_rd_en_s = 1'b0;
      endcase
    end else begin
      in_rd_en_s = 1'b0;
    end
  end

  assign out_wr_en_s = (state_q == OUTPUT) && !bus.out_full;
  // Past the last input pixel, FILTER still shifts so the tail of the frame
  // reaches the centre; zeros fill the vacated slots.
  assign shift_en_s  = in_rd_en_s || ((state_q == FILTER) && exhausted_s);
  assign shift_in_s  = in_rd_en_s ? bus.in_dout : 8'h00;

  assign bus.in_rd_en  = in_rd_en_s;
  assign bus.out_wr_en = out_wr_en_s;
  assign bus.out_din   = out_wr_en_s ? result_q : 8'h00;

  for (genvar dy = 0; dy < 5; dy++) begin : g_row
    for (genvar dx = 0; dx < 5; dx++) begin : g_col
      assign taps_s[dy * 5 + dx] = sr_q[CENTRE + (dy - 2) * WIDTH + (dx - 2)];
    end
  end

  gaussian_window_sum u_sum (
    .taps_i   (taps_s),
    .result_o (sum_s)
  );

  assign result_d = border_s ? sr_q[CENTRE] : sum_s;

  // Window shift register: newest byte enters at the top index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SR_LEN; i++) begin
        sr_q[i] <= 8'h00;
      end
    end else if (shift_en_s) begin
      for (int i = 0; i < SR_LEN - 1; i++) begin
        sr_q[i] <= sr_q[i + 1];
      end
      sr_q[SR_LEN - 1] <= shift_in_s;
    end
  end

  // Control FSM with pixel counters and the registered result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= PROLOGUE;
      rd_count_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      result_q   <= 8'h00;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        PROLOGUE: begin
          if (in_rd_en_s) begin
            rd_count_q <= rd_count_q + CNT_ONE;
            if (rd_count_q == PROLOG_C - CNT_ONE) begin
              state_q <= FILTER;
            end
          end
        end
        FILTER: begin
          if (filter_go_s) begin
            result_q <= result_d;
            if (in_rd_en_s) begin
              rd_count_q <= rd_count_q + CNT_ONE;
            end
            state_q <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (!bus.out_full) begin
            if (last_pix_s) begin
              row_q      <= '0;
              col_q      <= '0;
              rd_count_q <= '0;
              state_q    <= PROLOGUE;
            end else begin
              if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
              end else begin
                col_q <= col_q + COL_W'(1);
              end
              state_q <= FILTER;
            end
          end
        end
        default: begin
          state_q    <= PROLOGUE;
          rd_count_q <= '0;
          col_q      <= '0;
          row_q      <= '0;
        end
      endcase
    end
  end

endmodule
